// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared pong geometry, game state and direction encodings.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int BALL_SIZE    = 5;
    localparam int RACKET1_X    = 20;
    localparam int RACKET2_X    = 620;
    localparam int RACKET_W     = 10;
    localparam int RACKET_H     = 40;
    localparam int SPEED        = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    typedef enum logic [1:0] {
        ST_SERVE  = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SCORED = 2'd2,
        ST_OVER   = 2'd3
    } ball_state_t;

    // INC means right on x and down on y
    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Purpose  : Two saturating 4-bit scores, point pulses and win look-ahead.
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int WIN_SCORE = pong_pkg::WIN_SCORE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_p1,
    input  logic       inc_p2,
    input  logic       clear,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       point_p1,
    output logic       point_p2,
    output logic       win_next
);

    localparam logic [3:0] c_WIN = 4'(WIN_SCORE);
    localparam logic [3:0] c_MAX = 4'hF;

    logic [3:0] r_score_p1;
    logic [3:0] r_score_p2;
    logic       r_point_p1;
    logic       r_point_p2;
    logic [3:0] w_inc_p1;
    logic [3:0] w_inc_p2;

    assign w_inc_p1 = (r_score_p1 == c_MAX) ? r_score_p1 : r_score_p1 + 4'd1;
    assign w_inc_p2 = (r_score_p2 == c_MAX) ? r_score_p2 : r_score_p2 + 4'd1;

    // Tells the caller during the scoring cycle whether this point ends the game
    assign win_next = (inc_p1 && (w_inc_p1 == c_WIN)) || (inc_p2 && (w_inc_p2 == c_WIN));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_score_p1 <= '0;
            r_score_p2 <= '0;
            r_point_p1 <= 1'b0;
            r_point_p2 <= 1'b0;
        end else begin
            r_point_p1 <= inc_p1;
            r_point_p2 <= inc_p2;
            if (clear) begin
                r_score_p1 <= '0;
                r_score_p2 <= '0;
            end else begin
                if (inc_p1) r_score_p1 <= w_inc_p1;
                if (inc_p2) r_score_p2 <= w_inc_p2;
            end
        end
    end

    assign score_p1 = r_score_p1;
    assign score_p2 = r_score_p2;
    assign point_p1 = r_point_p1;
    assign point_p2 = r_point_p2;

endmodule
`default_nettype wire

// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
// Module   : ball_engine
// Purpose  : Pong ball motion, wall/racket bounces, scoring and serve sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module ball_engine #(
    parameter int SCREEN_W     = pong_pkg::SCREEN_W,
    parameter int SCREEN_H     = pong_pkg::SCREEN_H,
    parameter int BALL_SIZE    = pong_pkg::BALL_SIZE,
    parameter int RACKET1_X    = pong_pkg::RACKET1_X,
    parameter int RACKET2_X    = pong_pkg::RACKET2_X,
    parameter int RACKET_W     = pong_pkg::RACKET_W,
    parameter int RACKET_H     = pong_pkg::RACKET_H,
    parameter int SPEED        = pong_pkg::SPEED,
    parameter int SERVE_FRAMES = pong_pkg::SERVE_FRAMES,
    parameter int WIN_SCORE    = pong_pkg::WIN_SCORE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] racket1_y,
    input  logic [9:0] racket2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       point_p1,
    output logic       point_p2,
    output logic       game_over
);

    import pong_pkg::*;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0]       c_X0         = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]       c_Y0         = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [CNT_W-1:0] c_SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [10:0]      c_W          = 11'(SCREEN_W);
    localparam logic [10:0]      c_H          = 11'(SCREEN_H);
    localparam logic [10:0]      c_BALL       = 11'(BALL_SIZE);
    localparam logic [10:0]      c_SPEED      = 11'(SPEED);
    localparam logic [10:0]      c_R1_EDGE    = 11'(RACKET1_X + RACKET_W);
    localparam logic [10:0]      c_R2X        = 11'(RACKET2_X);
    localparam logic [10:0]      c_RH         = 11'(RACKET_H);

    ball_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    dir_t             r_dir_x;
    dir_t             r_dir_y;
    logic             r_scorer_p1;

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_r1;
    logic [10:0] w_r2;
    logic [9:0]  w_nx;
    logic [9:0]  w_ny;
    dir_t        w_ndx;
    dir_t        w_ndy;
    logic        w_ov1;
    logic        w_ov2;
    logic        w_miss_p1;
    logic        w_miss_p2;
    logic        w_inc_p1;
    logic        w_inc_p2;
    logic        w_clear;
    logic        w_win_next;

    assign w_x  = {1'b0, r_x};
    assign w_y  = {1'b0, r_y};
    assign w_r1 = {1'b0, racket1_y};
    assign w_r2 = {1'b0, racket2_y};

    // All checks use pre-tick position; wall and racket outcomes are independent
    always_comb begin
        w_ny      = r_y;
        w_ndy     = r_dir_y;
        w_nx      = r_x;
        w_ndx     = r_dir_x;
        w_miss_p1 = 1'b0;
        w_miss_p2 = 1'b0;

        if (r_dir_y == DIR_INC) begin
            if (w_y + c_BALL + c_SPEED >= c_H - 11'd1) begin
                w_ny  = 10'(c_H - 11'd1 - c_BALL);
                w_ndy = DIR_DEC;
            end else begin
                w_ny  = 10'(w_y + c_SPEED);
            end
        end else begin
            if (w_y < c_SPEED) begin
                w_ny  = '0;
                w_ndy = DIR_INC;
            end else begin
                w_ny  = 10'(w_y - c_SPEED);
            end
        end

        w_ov1 = (w_y + c_BALL >= w_r1) && (w_y <= w_r1 + c_RH);
        w_ov2 = (w_y + c_BALL >= w_r2) && (w_y <= w_r2 + c_RH);

        if (r_dir_x == DIR_DEC) begin
            if ((w_x >= c_R1_EDGE + 11'd1) && (w_x - c_SPEED <= c_R1_EDGE) && w_ov1) begin
                w_nx  = 10'(c_R1_EDGE + 11'd1);
                w_ndx = DIR_INC;
            end else if (w_x < c_SPEED) begin
                w_miss_p2 = 1'b1;
            end else begin
                w_nx = 10'(w_x - c_SPEED);
            end
        end else begin
            if ((w_x + c_BALL < c_R2X) && (w_x + c_BALL + c_SPEED >= c_R2X) && w_ov2) begin
                w_nx  = 10'(c_R2X - c_BALL - 11'd1);
                w_ndx = DIR_DEC;
            end else if (w_x + c_BALL + c_SPEED >= c_W) begin
                w_miss_p1 = 1'b1;
            end else begin
                w_nx = 10'(w_x + c_SPEED);
            end
        end
    end

    assign w_inc_p1 = (r_state == ST_SCORED) && r_scorer_p1;
    assign w_inc_p2 = (r_state == ST_SCORED) && !r_scorer_p1;
    assign w_clear  = (r_state == ST_OVER) && start;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_SERVE;
            r_cnt       <= '0;
            r_x         <= c_X0;
            r_y         <= c_Y0;
            r_dir_x     <= DIR_INC;
            r_dir_y     <= DIR_INC;
            r_scorer_p1 <= 1'b0;
        end else begin
            case (r_state)
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (r_cnt == c_SERVE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_PLAY;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        r_y     <= w_ny;
                        r_dir_y <= w_ndy;
                        if (w_miss_p1 || w_miss_p2) begin
                            r_state     <= ST_SCORED;
                            r_scorer_p1 <= w_miss_p1;
                        end else begin
                            r_x     <= w_nx;
                            r_dir_x <= w_ndx;
                        end
                    end
                end
                ST_SCORED: begin
                    r_x     <= c_X0;
                    r_y     <= c_Y0;
                    r_cnt   <= '0;
                    // Serve travels toward the player who just lost the point
                    r_dir_x <= r_scorer_p1 ? DIR_INC : DIR_DEC;
                    r_state <= w_win_next ? ST_OVER : ST_SERVE;
                end
                ST_OVER: begin
                    if (start) begin
                        r_dir_x <= DIR_INC;
                        r_dir_y <= DIR_INC;
                        r_state <= ST_SERVE;
                    end
                end
                default: r_state <= ST_SERVE;
            endcase
        end
    end

    score_keeper #(
        .WIN_SCORE (WIN_SCORE)
    ) u_score_keeper (
        .clk      (clk),
        .reset    (reset),
        .inc_p1   (w_inc_p1),
        .inc_p2   (w_inc_p2),
        .clear    (w_clear),
        .score_p1 (score_p1),
        .score_p2 (score_p2),
        .point_p1 (point_p1),
        .point_p2 (point_p2),
        .win_next (w_win_next)
    );

    assign ball_x    = r_x;
    assign ball_y    = r_y;
    assign game_over = (r_state == ST_OVER);

endmodule
`default_nettype wire
